// File: rtl/huc_mem_ctrl.sv
// Byte-wide request port to 16-bit asynchronous SRAM bridge.
// One SRAM access per rising edge of a registered read or write strobe; reads win a tie.
module huc_mem_ctrl #(
  parameter int WAIT_CYC = 3,
  parameter int AW       = 19
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_ce,
  input  logic          req_oe,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_dati,
  output logic [7:0]    req_dato,
  output logic          busy,
  output logic [AW-2:0] mem_addr,
  input  logic [15:0]   mem_dq_i,
  output logic [15:0]   mem_dq_o,
  output logic          mem_dq_oe,
  output logic          mem_ce_n,
  output logic          mem_oe_n,
  output logic          mem_we_n,
  output logic          mem_ub_n,
  output logic          mem_lb_n
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_WR      = 3'd2;
  localparam logic [2:0] S_WR_HOLD = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC - 1);

  logic       rd_r;
  logic       wr_r;
  logic       rd_d_r;
  logic       wr_d_r;
  logic [2:0] state_r;
  logic [2:0] state_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_s;
  logic       op_rd_r;
  logic       lane_r;
  logic       lane_s;
  logic       rd_rise_s;
  logic       wr_rise_s;
  logic       rd_start_s;
  logic       wr_start_s;
  logic       capture_s;

  logic       ce_n_s;
  logic       oe_n_s;
  logic       we_n_s;
  logic       ub_n_s;
  logic       lb_n_s;
  logic       dq_oe_s;
  logic       busy_s;

  assign rd_rise_s  = rd_r & ~rd_d_r;
  assign wr_rise_s  = wr_r & ~wr_d_r;
  assign rd_start_s = (state_r == S_IDLE) & rd_rise_s;
  assign wr_start_s = (state_r == S_IDLE) & ~rd_rise_s & wr_rise_s;
  assign capture_s  = (state_r == S_RD) & (cnt_r == 4'd0);

  // Strobe synchronisers and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_r   <= 1'b0;
      wr_r   <= 1'b0;
      rd_d_r <= 1'b0;
      wr_d_r <= 1'b0;
    end else begin
      rd_r   <= req_ce & req_oe;
      wr_r   <= req_ce & req_we;
      rd_d_r <= rd_r;
      wr_d_r <= wr_r;
    end
  end

  // Next state and strobe-width counter; DONE waits for the starting strobe to drop.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (rd_rise_s) begin
          state_s = S_RD;
          cnt_s   = WAIT_LD;
        end else if (wr_rise_s) begin
          state_s = S_WR;
          cnt_s   = WAIT_LD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD: begin
        if (cnt_r == 4'd0) begin
          state_s = S_DONE;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      S_WR: begin
        if (cnt_r == 4'd0) begin
          state_s = S_WR_HOLD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      S_WR_HOLD: begin
        state_s = S_DONE;
      end
      S_DONE: begin
        if (op_rd_r ? ~rd_r : ~wr_r) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // SRAM control values for the state being entered, so the pins come straight from flops.
  always_comb begin
    ce_n_s  = 1'b1;
    oe_n_s  = 1'b1;
    we_n_s  = 1'b1;
    ub_n_s  = 1'b1;
    lb_n_s  = 1'b1;
    dq_oe_s = 1'b0;
    busy_s  = 1'b0;
    if (rd_start_s || wr_start_s) begin
      lane_s = req_addr[0];
    end else begin
      lane_s = lane_r;
    end
    case (state_s)
      S_RD: begin
        ce_n_s = 1'b0;
        oe_n_s = 1'b0;
        ub_n_s = 1'b0;
        lb_n_s = 1'b0;
        busy_s = 1'b1;
      end
      S_WR: begin
        ce_n_s  = 1'b0;
        we_n_s  = 1'b0;
        ub_n_s  = ~lane_s;
        lb_n_s  = lane_s;
        dq_oe_s = 1'b1;
        busy_s  = 1'b1;
      end
      S_WR_HOLD: begin
        ce_n_s  = 1'b0;
        ub_n_s  = ~lane_s;
        lb_n_s  = lane_s;
        dq_oe_s = 1'b1;
        busy_s  = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // FSM state, counter and latched request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= 4'd0;
      op_rd_r  <= 1'b0;
      lane_r   <= 1'b0;
      mem_addr <= '0;
      mem_dq_o <= 16'h0000;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (rd_start_s || wr_start_s) begin
        op_rd_r  <= rd_start_s;
        lane_r   <= req_addr[0];
        mem_addr <= req_addr[AW-1:1];
      end
      if (wr_start_s) begin
        mem_dq_o <= {req_dati, req_dati};
      end
    end
  end

  // Registered SRAM pins and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ce_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_ub_n  <= 1'b1;
      mem_lb_n  <= 1'b1;
      mem_dq_oe <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_ce_n  <= ce_n_s;
      mem_oe_n  <= oe_n_s;
      mem_we_n  <= we_n_s;
      mem_ub_n  <= ub_n_s;
      mem_lb_n  <= lb_n_s;
      mem_dq_oe <= dq_oe_s;
      busy      <= busy_s;
    end
  end

  // Read data is taken at the end of the last strobe cycle and held until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_dato <= 8'h00;
    end else if (capture_s) begin
      req_dato <= lane_r ? mem_dq_i[15:8] : mem_dq_i[7:0];
    end
  end

endmodule
